// File: rtl/student_fir_driver_pkg.sv
// Shared types and helpers for student_fir_driver: FSM state encoding and the
// accumulator shift/saturate function used to produce the output sample.
package student_fir_driver_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2,
    GAP    = 2'd3
  } fir_drv_state_t;

  localparam int SAT_W = 64;
  localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAT_MIN = 16'sh8000;

  // Arithmetic shift, then clamp into a dsize-bit signed range (sign-extended result).
  function automatic logic signed [SAT_W-1:0] sat_shift(input logic signed [SAT_W-1:0] acc,
                                                        input int shift,
                                                        input int dsize);
    logic signed [SAT_W-1:0] t;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    t  = acc >>> shift;
    hi = (64'sd1 <<< (dsize - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (t > hi) begin
      sat_shift = hi;
    end else if (t < lo) begin
      sat_shift = lo;
    end else begin
      sat_shift = t;
    end
  endfunction

endpackage

// File: rtl/student_sync_fifo.sv
// Small synchronous FIFO (power-of-two depth) with synchronous active-high reset.
module student_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == {(PTR_W+1){1'b0}});
  assign rd_data_o = mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    do_push_s = push_i && !full_o;
    do_pop_s  = pop_i && !empty_o;
    wr_ptr_d  = do_push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d  = do_pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {(PTR_W+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

endmodule

// File: rtl/student_fir_driver.sv
// Buffers upstream samples, strobes them one at a time into the FIR, then scales and
// saturates the FIR result onto a valid/ready stream. STUDENT_FIR_DRIVER_ROUND_EN adds round-half-up.
module student_fir_driver
  import student_fir_driver_pkg::*;
#(
  parameter int DATA_SIZE         = 16,
  parameter int DATA_SIZE_FIR_OUT = 32,
  parameter int FIFO_DEPTH        = 4,
  parameter int OUT_SHIFT         = 15,
  parameter int TIMEOUT_CYCLES    = 4096
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         s_valid_i,
  output logic                         s_ready_o,
  input  logic [DATA_SIZE-1:0]         s_data_i,
  output logic                         fir_valid_strobe_o,
  output logic [DATA_SIZE-1:0]         fir_sample_o,
  input  logic                         fir_valid_strobe_i,
  input  logic [DATA_SIZE_FIR_OUT-1:0] fir_y_i,
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic [DATA_SIZE-1:0]         m_data_o,
  output logic                         busy_o,
  output logic                         timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  fir_drv_state_t          state_q, state_d;
  logic                    strobe_q, strobe_d;
  logic [DATA_SIZE-1:0]    sample_q, sample_d;
  logic                    m_valid_q, m_valid_d;
  logic [DATA_SIZE-1:0]    m_data_q, m_data_d;
  logic                    busy_q, busy_d;
  logic                    timeout_q, timeout_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    fifo_full_s, fifo_empty_s, fifo_pop_s;
  logic [DATA_SIZE-1:0]    fifo_data_s;
  logic signed [SAT_W-1:0] acc_s;
  logic [DATA_SIZE-1:0]    scaled_s;

  student_sync_fifo #(
    .WIDTH (DATA_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (s_valid_i),
    .wr_data_i (s_data_i),
    .pop_i     (fifo_pop_s),
    .rd_data_o (fifo_data_s),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s)
  );

  // Sign-extend with headroom so the rounding offset can never overflow.
  always_comb begin
    acc_s = SAT_W'(signed'(fir_y_i));
`ifdef STUDENT_FIR_DRIVER_ROUND_EN
    acc_s = acc_s + (64'sd1 <<< (OUT_SHIFT - 1));
`endif
    scaled_s = DATA_SIZE'(sat_shift(acc_s, OUT_SHIFT, DATA_SIZE));
  end

  // Sequencer next-state: one sample in flight, GAP keeps strobes two low cycles apart.
  always_comb begin
    state_d    = state_q;
    strobe_d   = 1'b0;
    sample_d   = sample_q;
    m_data_d   = m_data_q;
    timeout_d  = timeout_q;
    cnt_d      = cnt_q;
    fifo_pop_s = 1'b0;
    if (m_valid_q && m_ready_i) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s && !m_valid_q) begin
          fifo_pop_s = 1'b1;
          sample_d   = fifo_data_s;
          strobe_d   = 1'b1;
          state_d    = STROBE;
        end else begin
          state_d = IDLE;
        end
      end
      STROBE: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = WAIT;
      end
      WAIT: begin
        if (fir_valid_strobe_i) begin
          m_valid_d = 1'b1;
          m_data_d  = scaled_s;
          state_d   = GAP;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = GAP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == STROBE) || (state_d == WAIT);
  end

  // Sequencer and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      strobe_q  <= 1'b0;
      sample_q  <= {DATA_SIZE{1'b0}};
      m_valid_q <= 1'b0;
      m_data_q  <= {DATA_SIZE{1'b0}};
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      strobe_q  <= strobe_d;
      sample_q  <= sample_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign s_ready_o          = !rst_i && !fifo_full_s;
  assign fir_valid_strobe_o = strobe_q;
  assign fir_sample_o       = sample_q;
  assign m_valid_o          = m_valid_q;
  assign m_data_o           = m_data_q;
  assign busy_o             = busy_q;
  assign timeout_o          = timeout_q;

endmodule

// File: tb/tb_student_fir_driver.sv
// Scoreboard bench for student_fir_driver with a FIR responder model; honours STUDENT_FIR_DRIVER_ROUND_EN.
`timescale 1ns/1ps
module tb_student_fir_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_ready;
  logic [15:0] s_data;
  logic        fir_strb_o, fir_strb_i;
  logic [15:0] fir_sample;
  logic [31:0] fir_y;
  logic        m_valid, m_ready;
  logic [15:0] m_data;
  logic        busy, timeout;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int strobes = 0;
  int last_strobe = -100;
  int late_req_cnt = 0;
  int late_done = 0;
  bit reply_en = 1'b1;
  logic [15:0] samp_q[$];
  logic [31:0] y_q[$];
  logic [15:0] exp_q[$];

  student_fir_driver #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .s_valid_i          (s_valid),
    .s_ready_o          (s_ready),
    .s_data_i           (s_data),
    .fir_valid_strobe_o (fir_strb_o),
    .fir_sample_o       (fir_sample),
    .fir_valid_strobe_i (fir_strb_i),
    .fir_y_i            (fir_y),
    .m_valid_o          (m_valid),
    .m_ready_i          (m_ready),
    .m_data_o           (m_data),
    .busy_o             (busy),
    .timeout_o          (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Strobe monitor: sample order and strobe spacing
  initial forever begin
    @(negedge clk);
    if (fir_strb_o) begin
      strobes++;
      chk("strobe_gap", (cyc - last_strobe) >= 3, 1);
      if (samp_q.size() == 0) chk("unexp_strobe", samp_q.size(), 1);
      else chk("fir_sample", fir_sample, samp_q.pop_front());
      last_strobe = cyc;
    end
  end

  // FIR model: replies 5 cycles after a strobe; can also send an unsolicited late strobe
  initial begin
    fir_strb_i = 1'b0;
    fir_y = 32'h0;
    forever begin
      @(negedge clk);
      if (fir_strb_o && reply_en) begin
        repeat (4) @(posedge clk);
        #1;
        fir_y = (y_q.size() != 0) ? y_q.pop_front() : 32'h0;
        fir_strb_i = 1'b1;
        @(posedge clk); #1;
        fir_strb_i = 1'b0;
      end else if (late_done != late_req_cnt) begin
        late_done++;
        @(posedge clk); #1;
        fir_y = 32'h0010_0000;
        fir_strb_i = 1'b1;
        @(posedge clk); #1;
        fir_strb_i = 1'b0;
      end
    end
  end

  // Output monitor: every accepted result is popped from the scoreboard
  initial forever begin
    @(negedge clk);
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) chk("unexp_result", exp_q.size(), 1);
      else chk("m_data", m_data, exp_q.pop_front());
    end
  end

  task automatic push(input logic [15:0] d, input logic [31:0] y,
                      input logic [15:0] et, input logic [15:0] er, input bit want);
    int n = 0;
    s_valid = 1'b1;
    s_data = d;
    while (!s_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("push_timeout", n, 0);
    @(posedge clk); #1;
    s_valid = 1'b0;
    samp_q.push_back(d);
    if (want) begin
      y_q.push_back(y);
`ifdef STUDENT_FIR_DRIVER_ROUND_EN
      exp_q.push_back(er);
`else
      exp_q.push_back(et);
`endif
    end
  endtask

  task automatic wait_mvalid();
    int n = 0;
    while (!m_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("mvalid_timeout", n, 0);
  endtask

  task automatic drain();
    int n = 0;
    m_ready = 1'b1;
    while ((exp_q.size() != 0 || m_valid) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic wait_strobe_neg();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fir_strb_o && n < 50);
    if (n >= 50) chk("strobe_timeout", n, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int n;
    int seen;
    rst = 1'b1; s_valid = 1'b0; s_data = 16'h0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_strobe", fir_strb_o, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_m_data", m_data, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("s_ready_idle", s_ready, 1);

    // Basic path with held output
    push(16'h1234, 32'h0012_3456, 16'h0024, 16'h0024, 1'b1);
    wait_mvalid();
    repeat (3) @(posedge clk);
    #1;
    chk("hold_m_valid", m_valid, 1);
    chk("hold_m_data", m_data, 16'h0024);
    chk("hold_busy", busy, 0);
    chk("basic_strobes", strobes, 1);
    drain();

    // Saturation, rounding and boundary vectors
    push(16'h0001, 32'h4000_0000, 16'h7FFF, 16'h7FFF, 1'b1);
    push(16'h0002, 32'h8000_0000, 16'h8000, 16'h8000, 1'b1);
    push(16'h0003, 32'hC000_0000, 16'h8000, 16'h8000, 1'b1);
    push(16'h0004, 32'h0000_C000, 16'h0001, 16'h0002, 1'b1);
    push(16'hFFFF, 32'hFFFF_8000, 16'hFFFF, 16'hFFFF, 1'b1);
    push(16'h7FFF, 32'h3FFF_8000, 16'h7FFF, 16'h7FFF, 1'b1);
    drain();

    // Backpressure: one result held, four buffered, sixth refused
    m_ready = 1'b0;
    s0 = strobes;
    push(16'h0101, 32'h0001_0000, 16'h0002, 16'h0002, 1'b1);
    wait_mvalid();
    for (int k = 2; k <= 5; k++)
      push(16'h0100 + 16'(k), 32'(k) << 16, 16'(2 * k), 16'(2 * k), 1'b1);
    chk("bp_full", s_ready, 0);
    chk("bp_one_strobe", strobes - s0, 1);
    s_valid = 1'b1; s_data = 16'h0106;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_refused", s_ready, 0);
    s_valid = 1'b0;
    drain();
    chk("bp_all_strobes", strobes - s0, 5);

    // Timeout: FIR never answers
    reply_en = 1'b0;
    push(16'h00AA, 32'h0, 16'h0, 16'h0, 1'b0);
    wait_strobe_neg();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!timeout && n < 60);
    chk("timeout_latency", n, 17);
    @(posedge clk); #1;
    chk("timeout_idle_busy", busy, 0);
    reply_en = 1'b1;
    push(16'h00BB, 32'h0005_0000, 16'h000A, 16'h000A, 1'b1);
    drain();
    chk("timeout_sticky", timeout, 1);

    // Reset while waiting on the FIR
    reply_en = 1'b0;
    push(16'h0CCC, 32'h0, 16'h0, 16'h0, 1'b0);
    wait_strobe_neg();
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_s_ready", s_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_timeout", timeout, 0);
    chk("mid_rst_sample", fir_sample, 0);
    rst = 1'b0;
    late_req_cnt++;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (m_valid || fir_strb_o || busy) seen++;
    end
    chk("post_rst_quiet", seen, 0);
    chk("post_rst_m_data", m_data, 0);
    chk("post_rst_ready", s_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
